quan_sa_psum_acc_v11: RTL
=========================

Name: quan_sa_psum_acc_v11

Overview:
- Parametrised partial-sum accumulator behind the systolic-array core.
- Takes per-column PE result words from the array's output path over K input-channel tiles, either as 8x8 mode (2 lanes/column) or 1x8 mode (4 lanes/column).
- Accumulates tiles with signed saturation and presents one stable result vector under a valid/ready handshake to the quantisation/write-back stage.
- Adds what the current array output lacks: multi-tile accumulation, a configurable tile count, backpressure and saturation reporting.

Parameters:
- COLS, 16, number of SA columns (result words per beat)
- PE_W, 64, bits per column result word
- W88, 24, signed lane width in mode 0 (2 lanes at [0+:W88], [W88+:W88])
- W18, 16, signed lane width in mode 1 (4 lanes at [k*W18+:W18], k=0..3)
- ACC_W, 32, signed accumulator width per lane
- KCNT_W, 8, width of the tile counter

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous, active-high
- cfg_valid, in, 1, configuration offered
- cfg_ready, out, 1, configuration accepted (high only in IDLE)
- cfg_mode, in, 1, 0 = 8x8 (2 lanes), 1 = 1x8 (4 lanes)
- cfg_k_tiles, in, KCNT_W, number of beats to accumulate; 0 is treated as 1
- in_valid, in, 1, PE result beat valid
- in_ready, out, 1, beat accepted (high only in ACCUM)
- in_data, in, COLS*PE_W, column c at [c*PE_W+:PE_W]
- out_valid, out, 1, result vector valid
- out_ready, in, 1, downstream accepts
- out_data, out, COLS*4*ACC_W, lane k of column c at [(c*4+k)*ACC_W+:ACC_W]
- out_mode, out, 1, mode latched for this result
- out_sat, out, 1, at least one lane saturated during this job

Behaviour:
- Reset is synchronous and active-high, clock clk. On reset: state IDLE; all accumulators, tile counter, out_data, out_mode and out_sat cleared; out_valid=0.
- Reset mid-job aborts the job; no partial result is ever emitted.
- FSM IDLE:
  - cfg_ready=1, in_ready=0.
  - On cfg_valid: latch mode and k_tiles (0 becomes 1), clear counter and out_sat, go to ACCUM.
- FSM ACCUM:
  - in_ready=1.
  - Each beat with in_valid&in_ready: sign-extend the lanes of the latched mode to ACC_W.
  - First beat loads the accumulators; later beats do a saturating add (clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]).
  - Any clamp sets out_sat (sticky for the job).
  - Mode 0: lanes 2,3 of every column are held at 0.
  - Counter increments per accepted beat. When the accepted beat makes counter == k_tiles, go to DRAIN.
  - in_valid low stalls with no state change.
- FSM DRAIN:
  - out_valid=1 from the cycle after the final beat is accepted (1-cycle latency).
  - cfg_ready=0, in_ready=0.
  - out_data, out_mode and out_sat are held stable while out_valid&!out_ready.
  - On out_ready: out_valid falls next cycle and FSM returns to IDLE; accumulators are not cleared, because the next job reloads them.
- Boundary cases:
  - cfg_valid in ACCUM/DRAIN is ignored (cfg_ready=0).
  - in_valid in IDLE/DRAIN is not accepted.
  - k_tiles = 2^KCNT_W-1 needs no counter wrap; the counter width is sufficient.
  - out_ready asserted while out_valid=0 has no effect.
- Arithmetic: lanes are two's-complement. The saturation check uses an ACC_W+1 bit sum, comparing the top two bits.

Optional Feature:
- Macro QUAN_SA_ACC_RELU_EN.
- When defined: out_data lanes are clamped at 0 for negative values (ReLU), applied combinationally on the registered accumulators at the output. out_sat is unaffected by ReLU.
- When undefined: out_data is the raw signed accumulators.

Decomposition:
- Shared package quan_sa_pkg holds:
  - the mode encoding constants (MODE_88=0, MODE_18=1)
  - the lane-count-per-mode constants
  - the FSM state typedef/localparams (IDLE, ACCUM, DRAIN)
- One natural sub-module: quan_sat_add_lane (parametrised on ACC_W). It takes a sign-extended lane, the accumulator, and load/add select, and returns the next value plus a sat flag. It is instantiated COLS*4 times.

Test Plan:
- Mode 0, k=3; column 0 lanes (+100, -50) on each beat -> out_data col0 lane0=300, lane1=-150, lanes 2,3=0; out_sat=0; out_valid one cycle after beat 3.
- Mode 1, k=2; all lanes 16'h7FFF -> every lane reads 65534; out_mode=1.
- Saturation: ACC_W=32, mode 0, k=255, lane0=+2^23-1 every beat -> no clamp expected (sum < 2^31), out_sat=0. Rerun with ACC_W=28 -> lane0=2^27-1, out_sat=1.
- Backpressure: hold out_ready=0 for 10 cycles in DRAIN -> out_data stable; cfg_ready=0; in_ready=0; in_valid pulses ignored.
- Reset in ACCUM after 1 of 4 beats, then new job k=1, lane0=7 -> result 7, no residue from the aborted job.
- With QUAN_SA_ACC_RELU_EN: mode 1, k=1, lane=-5 -> lane reads 0. Without the macro -> lane reads -5.

Source files
------------

// File: rtl/quan_sa_pkg.sv
// Shared definitions for the systolic-array partial-sum accumulator:
// mode encodings, lanes per mode and the controller state type.
package quan_sa_pkg;

   // Mode encodings as seen on cfg_mode / out_mode
   localparam logic MODE_88 = 1'b0;
   localparam logic MODE_18 = 1'b1;

   // Active lanes per column word in each mode, and the lanes reserved per column
   localparam int LANES_88  = 2;
   localparam int LANES_18  = 4;
   localparam int LANES_MAX = 4;

   // Controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/quan_sat_add_lane.sv
// One accumulator lane: either loads the sign-extended input lane or adds it
// to the running accumulator with two's-complement saturation.
module quan_sat_add_lane #(
   parameter int ACC_W = 32
) (
   input  logic [ACC_W-1:0] lane,
   input  logic [ACC_W-1:0] acc,
   input  logic             load,
   output logic [ACC_W-1:0] sum,
   output logic             sat
);

   localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

   // One extra bit of headroom; the top two bits disagree exactly on overflow
   logic [ACC_W:0] wide;

   assign wide = {lane[ACC_W-1], lane} + {acc[ACC_W-1], acc};
   assign sat  = !load && (wide[ACC_W] != wide[ACC_W-1]);

   // Select the loaded value, the clamped value or the plain sum
   always_comb begin
      sum = wide[ACC_W-1:0];
      if (load) begin
         sum = lane;
      end else if (sat) begin
         sum = wide[ACC_W] ? MIN_V : MAX_V;
      end
   end

endmodule

// File: rtl/quan_sa_psum_acc_v11.sv
// Partial-sum accumulator behind the systolic array. Accumulates k_tiles
// beats of per-column PE results (2 lanes/column in 8x8 mode, 4 lanes in
// 1x8 mode) with signed saturation and presents the result under valid/ready.
// Optional build macro: QUAN_SA_ACC_RELU_EN clamps negative output lanes to 0.
module quan_sa_psum_acc_v11
   import quan_sa_pkg::*;
#(
   parameter int COLS   = 16,
   parameter int PE_W   = 64,
   parameter int W88    = 24,
   parameter int W18    = 16,
   parameter int ACC_W  = 32,
   parameter int KCNT_W = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic                        cfg_mode,
   input  logic [KCNT_W-1:0]           cfg_k_tiles,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [COLS*PE_W-1:0]        in_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [COLS*LANES_MAX*ACC_W-1:0] out_data,
   output logic                        out_mode,
   output logic                        out_sat
);

   localparam int NLANES = COLS * LANES_MAX;

   state_t              state_reg, state_next;
   logic                mode_reg;
   logic [KCNT_W-1:0]   k_reg;
   logic [KCNT_W-1:0]   cnt_reg;
   logic                sat_reg;
   logic                beat;
   logic                first_beat;
   logic                last_beat;
   logic [NLANES-1:0]   lane_sat;

   assign beat       = in_valid && in_ready;
   assign first_beat = (cnt_reg == '0);
   assign last_beat  = ((cnt_reg + KCNT_W'(1)) == k_reg);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and handshake outputs
   always_comb begin
      state_next = state_reg;
      cfg_ready  = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_next = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && last_beat) state_next = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Job configuration, tile counter and sticky saturation flag
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_reg <= MODE_88;
         k_reg    <= KCNT_W'(1);
         cnt_reg  <= '0;
         sat_reg  <= 1'b0;
      end else if (cfg_valid && cfg_ready) begin
         mode_reg <= cfg_mode;
         k_reg    <= (cfg_k_tiles == '0) ? KCNT_W'(1) : cfg_k_tiles;
         cnt_reg  <= '0;
         sat_reg  <= 1'b0;
      end else if (beat) begin
         cnt_reg <= cnt_reg + KCNT_W'(1);
         if (|lane_sat) sat_reg <= 1'b1;
      end
   end

   assign out_mode = mode_reg;
   assign out_sat  = sat_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NLANES; gi++) begin : g_lane
         localparam int COL = gi / LANES_MAX;
         localparam int LN  = gi % LANES_MAX;

         logic [W18-1:0]   raw18;
         logic [ACC_W-1:0] sx18;
         logic [ACC_W-1:0] ext;
         logic [ACC_W-1:0] acc_reg;
         logic [ACC_W-1:0] acc_next;

         assign raw18 = in_data[COL*PE_W + LN*W18 +: W18];
         assign sx18  = {{(ACC_W-W18){raw18[W18-1]}}, raw18};

         if (LN < LANES_88) begin : g_dual
            logic [W88-1:0]   raw88;
            logic [ACC_W-1:0] sx88;
            assign raw88 = in_data[COL*PE_W + LN*W88 +: W88];
            assign sx88  = {{(ACC_W-W88){raw88[W88-1]}}, raw88};
            assign ext   = (mode_reg == MODE_18) ? sx18 : sx88;
         end else begin : g_quad_only
            // Upper lanes carry zero in 8x8 mode so they load and stay at 0
            assign ext = (mode_reg == MODE_18) ? sx18 : '0;
         end

         quan_sat_add_lane #(
            .ACC_W (ACC_W)
         ) u_add (
            .lane (ext),
            .acc  (acc_reg),
            .load (first_beat),
            .sum  (acc_next),
            .sat  (lane_sat[gi])
         );

         // Lane accumulator: updates only on accepted beats, held otherwise
         always_ff @(posedge clk) begin
            if (reset) begin
               acc_reg <= '0;
            end else if (beat) begin
               acc_reg <= acc_next;
            end
         end

`ifdef QUAN_SA_ACC_RELU_EN
         assign out_data[gi*ACC_W +: ACC_W] = acc_reg[ACC_W-1] ? '0 : acc_reg;
`else
         assign out_data[gi*ACC_W +: ACC_W] = acc_reg;
`endif
      end
   endgenerate

endmodule
